// File: rtl/ttt_pkg.sv
// ttt_pkg: shared tic-tac-toe constants, cell/status codes and FSM state type
package ttt_pkg;
  localparam int N_CELLS = 9;
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1 = 2'b01;
  localparam logic [1:0] P2 = 2'b10;
  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] P1_WIN = 2'b01;
  localparam logic [1:0] P2_WIN = 2'b10;
  localparam logic [1:0] TIE = 2'b11;
  typedef enum logic [1:0] {PLAY = 2'd0, CHECK = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/game_ctrl.sv
// game_ctrl: tic-tac-toe move sequencer with an external winner checker
module game_ctrl
  import ttt_pkg::*;
#(
  parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic        move_valid,
  input  logic [3:0]  move_cell,
  input  logic [1:0]  status_in,
  output logic [17:0] board_out,
  output logic [1:0]  turn,
  output logic        move_ack,
  output logic        move_err,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [3:0]  move_count
);
  state_e state_q, state_d;
  logic [17:0] board_q, board_d, board_sh;
  logic [1:0] turn_q, turn_d, winner_q, winner_d;
  logic [3:0] cnt_q, cnt_d;
  logic ack_q, ack_d, err_q, err_d, legal;
  // a move is legal only on an on-board cell that is still empty
  assign board_sh = board_q >> {move_cell, 1'b0};
  assign legal = (move_cell < 4'(N_CELLS)) && (board_sh[1:0] == EMPTY);
  // next-state: new_game overrides everything, CHECK resolves the move just placed
  always_comb begin
    state_d = state_q;
    board_d = board_q;
    turn_d = turn_q;
    winner_d = winner_q;
    cnt_d = cnt_q;
    ack_d = 1'b0;
    err_d = 1'b0;
    if (new_game) begin
      state_d = PLAY;
      board_d = '0;
      turn_d = FIRST_PLAYER;
      winner_d = NONE;
      cnt_d = '0;
    end else if (state_q == PLAY) begin
      if (move_valid && legal) begin
        board_d = board_q | ({16'b0, turn_q} << {move_cell, 1'b0});
        cnt_d = cnt_q + 4'd1;
        ack_d = 1'b1;
        state_d = CHECK;
      end else begin
        err_d = move_valid;
      end
    end else begin
      err_d = move_valid;
      if (state_q == CHECK) begin
        winner_d = (status_in != NONE) ? status_in : (cnt_q == 4'(N_CELLS)) ? TIE : NONE;
        state_d = (winner_d != NONE) ? DONE : PLAY;
        turn_d = (winner_d != NONE) ? turn_q : (turn_q == P1) ? P2 : P1;
      end
    end
  end
  // state registers, cleared asynchronously so a reset takes effect immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PLAY;
      board_q <= '0;
      turn_q <= FIRST_PLAYER;
      winner_q <= NONE;
      cnt_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      turn_q <= turn_d;
      winner_q <= winner_d;
      cnt_q <= cnt_d;
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end
  assign board_out = board_q;
  assign turn = (state_q == DONE) ? 2'b00 : turn_q;
  assign move_ack = ack_q;
  assign move_err = err_q;
  assign game_over = (state_q == DONE);
  assign winner = winner_q;
  assign move_count = cnt_q;
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed game scenarios checked against a board-level reference model
module tb_game_ctrl;
  logic clk, rst, new_game, move_valid;
  logic [3:0] move_cell;
  logic [1:0] status_in, turn, winner, force_val;
  logic [17:0] board_out;
  logic move_ack, move_err, game_over, force_en;
  logic [3:0] move_count;
  int n_pass = 0, n_total = 0, ack_seen = 0, err_seen = 0;
  int lines [24] = '{0,1,2, 3,4,5, 6,7,8, 0,3,6, 1,4,7, 2,5,8, 0,4,8, 2,4,6};
  int m_board [9];
  int m_turn, m_cnt, m_win, m_st;
  bit m_over, m_ack, m_err, m_chk;

  game_ctrl #(.FIRST_PLAYER(2'b01)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .move_valid(move_valid),
    .move_cell(move_cell), .status_in(status_in), .board_out(board_out),
    .turn(turn), .move_ack(move_ack), .move_err(move_err),
    .game_over(game_over), .winner(winner), .move_count(move_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // winner checker: a completed line wins, a full board with no line is a tie
  function automatic logic [1:0] judge(input logic [17:0] b);
    logic [1:0] c;
    int full = 1;
    for (int l = 0; l < 8; l++) begin
      c = b[2*lines[3*l] +: 2];
      if (c != 2'b00 && c == b[2*lines[3*l+1] +: 2] && c == b[2*lines[3*l+2] +: 2]) return c;
    end
    for (int i = 0; i < 9; i++) if (b[2*i +: 2] == 2'b00) full = 0;
    return full ? 2'b11 : 2'b00;
  endfunction

  function automatic logic [17:0] pack_board();
    logic [17:0] b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_board[i]);
    return b;
  endfunction

  assign status_in = force_en ? force_val : judge(board_out);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // reference model: one placed stone per request, judged on the following cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_board[i]) m_board[i] = 0;
      m_turn = 1; m_cnt = 0; m_win = 0; m_over = 0; m_ack = 0; m_err = 0; m_chk = 0;
    end else begin
      m_ack = 0;
      m_err = 0;
      if (new_game) begin
        foreach (m_board[i]) m_board[i] = 0;
        m_turn = 1; m_cnt = 0; m_win = 0; m_over = 0; m_chk = 0;
      end else if (m_chk) begin
        m_err = move_valid;
        m_chk = 0;
        m_st = force_en ? int'(force_val) : int'(judge(pack_board()));
        if (m_st == 0 && m_cnt == 9) m_st = 3;
        if (m_st != 0) begin m_over = 1; m_win = m_st; end
        else m_turn = 3 - m_turn;
      end else if (m_over) begin
        m_err = move_valid;
      end else if (move_valid) begin
        if (move_cell < 9 && m_board[move_cell] == 0) begin
          m_board[move_cell] = m_turn;
          m_cnt++;
          m_ack = 1;
          m_chk = 1;
        end else m_err = 1;
      end
    end
  end

  // every-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    if (!rst) begin
      check("board", 32'(board_out), 32'(pack_board()));
      check("turn", 32'(turn), m_over ? 0 : m_turn);
      check("ack", 32'(move_ack), 32'(m_ack));
      check("err", 32'(move_err), 32'(m_err));
      check("over", 32'(game_over), 32'(m_over));
      check("winner", 32'(winner), m_win);
      check("count", 32'(move_count), m_cnt);
      if (move_ack && move_err) check("ack_err_excl", 1, 0);
      if (move_ack) ack_seen++;
      if (move_err) err_seen++;
    end
  end

  task automatic mv(input logic [3:0] c);
    @(negedge clk); move_valid = 1; move_cell = c;
    @(negedge clk); move_valid = 0;
    @(negedge clk);
  endtask

  task automatic restart();
    @(negedge clk); new_game = 1;
    @(negedge clk); new_game = 0;
  endtask

  initial begin
    int e0;
    rst = 1; new_game = 0; move_valid = 0; move_cell = 0; force_en = 0; force_val = 0;
    #3;
    check("rst_board", 32'(board_out), 0);
    check("rst_turn", 32'(turn), 1);
    check("rst_over", 32'(game_over), 0);
    @(negedge clk); rst = 0;
    ack_seen = 0;
    mv(0); mv(3); mv(1); mv(4); mv(2);
    check("p1_acks", ack_seen, 5);
    check("p1_over", 32'(game_over), 1);
    check("p1_winner", 32'(winner), 1);
    check("p1_turn", 32'(turn), 0);
    check("p1_board", 32'(board_out), 32'h295);
    restart();
    mv(4);
    e0 = err_seen;
    mv(4);
    check("dup_err", err_seen - e0, 1);
    check("dup_board", 32'(board_out), 32'h100);
    check("dup_turn", 32'(turn), 2);
    e0 = err_seen;
    mv(9); mv(15);
    check("range_err", err_seen - e0, 2);
    check("range_count", 32'(move_count), 1);
    restart();
    mv(0); mv(1); mv(2); mv(4); mv(3); mv(5); mv(7); mv(6); mv(8);
    check("tie_count", 32'(move_count), 9);
    check("tie_winner", 32'(winner), 3);
    check("tie_over", 32'(game_over), 1);
    check("tie_board", 32'(board_out), 32'h16A59);
    e0 = err_seen;
    mv(0);
    check("done_err", err_seen - e0, 1);
    check("done_board", 32'(board_out), 32'h16A59);
    @(negedge clk); new_game = 1; move_valid = 1; move_cell = 5;
    @(negedge clk); new_game = 0; move_valid = 0;
    check("ng_board", 32'(board_out), 0);
    check("ng_turn", 32'(turn), 1);
    check("ng_err", 32'(move_err), 0);
    mv(0); mv(3); mv(1); mv(4);
    force_en = 1; force_val = 2'b11;
    mv(2);
    force_en = 0;
    check("forced_tie", 32'(winner), 3);
    restart();
    mv(8);
    @(negedge clk); move_valid = 1; move_cell = 0;
    @(negedge clk); move_valid = 0;
    #2 rst = 1;
    #1;
    check("arst_board", 32'(board_out), 0);
    check("arst_turn", 32'(turn), 1);
    check("arst_ack", 32'(move_ack), 0);
    check("arst_count", 32'(move_count), 0);
    #1 rst = 0;
    mv(4);
    check("post_rst_count", 32'(move_count), 1);
    check("post_rst_board", 32'(board_out), 32'h100);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
